// File: rtl/bus_fifo_endpoint.sv
// bus_fifo_endpoint
//   Bus endpoint with a TX FIFO (user -> bus) and an RX FIFO (bus -> user).
//   Both FIFOs are circular buffers with show-ahead heads. Protocol errors
//   are recorded in sticky flags that stay set until reset.
//
//   Optional feature macro: ENDPOINT_ID_CHECK_EN
//     When this macro is defined, a delivered packet is kept only if its
//     destination field matches id or broadcast. Every packet that is
//     discarded this way increments the saturating counter misroute_cnt.
//
// Parameters
//   width      packet width; bits [width-1:width-8] hold the destination ID
//   depth      entries per FIFO (power of two, >= 2)
//   id         this endpoint's 8-bit address
//   broadcast  destination ID accepted by every endpoint
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   tx_wr/tx_data  user write into TX FIFO;  tx_full = TX holds depth entries
//   pndng/D_pop    TX non-empty request and show-ahead head to the bus
//   pop            bus consumes the TX head
//   push/D_push    bus delivers a packet into RX FIFO
//   rx_rd/rx_data  user read from RX FIFO (show-ahead head)
//   rx_empty       RX holds no entries;  rx_count = RX occupancy
//   err            sticky: [0] TX overflow, [1] pop on empty, [2] RX overflow
//   misroute_cnt   (ENDPOINT_ID_CHECK_EN only) count of discarded pushes
module bus_fifo_endpoint #(
    parameter int unsigned width     = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tx_wr,
    input  logic [width-1:0]         tx_data,
    output logic                     tx_full,
    output logic                     pndng,
    output logic [width-1:0]         D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [width-1:0]         D_push,
    input  logic                     rx_rd,
    output logic [width-1:0]         rx_data,
    output logic                     rx_empty,
    output logic [$clog2(depth):0]   rx_count,
    output logic [2:0]               err
`ifdef ENDPOINT_ID_CHECK_EN
    ,
    output logic [7:0]               misroute_cnt
`endif
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    // TX FIFO state
    logic [width-1:0] tx_mem [depth];
    logic [AW-1:0]    tx_rp, tx_wp;
    logic [CW-1:0]    tx_cnt;

    // RX FIFO state
    logic [width-1:0] rx_mem [depth];
    logic [AW-1:0]    rx_rp, rx_wp;
    logic [CW-1:0]    rx_cnt;

    logic tx_pop_ok, tx_wr_ok, tx_ovf, pop_empty;
    logic rx_full, rx_rd_ok, push_acc, rx_wr_ok, rx_ovf;

    assign pndng    = (tx_cnt != '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign D_pop    = tx_mem[tx_rp];

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_count = rx_cnt;
    assign rx_data  = rx_mem[rx_rp];

    // A pop that frees a slot in the same cycle lets a write into a full
    // FIFO proceed; the write lands in the slot being vacated.
    assign tx_pop_ok = pop & pndng;
    assign pop_empty = pop & ~pndng;
    assign tx_wr_ok  = tx_wr & (~tx_full | tx_pop_ok);
    assign tx_ovf    = tx_wr & tx_full & ~tx_pop_ok;

`ifdef ENDPOINT_ID_CHECK_EN
    logic [7:0] dest;
    logic       dest_match;
    logic       misroute;
    assign dest       = D_push[width-1 -: 8];
    assign dest_match = (dest == id) || (dest == broadcast);
    assign push_acc   = push & dest_match;
    assign misroute   = push & ~dest_match;
`else
    assign push_acc   = push;
`endif

    assign rx_rd_ok = rx_rd & ~rx_empty;
    assign rx_wr_ok = push_acc & (~rx_full | rx_rd_ok);
    assign rx_ovf   = push_acc & rx_full & ~rx_rd_ok;

    // Storage arrays carry no reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (tx_wr_ok) tx_mem[tx_wp] <= tx_data;
        if (rx_wr_ok) rx_mem[rx_wp] <= D_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_rp  <= '0;
            tx_wp  <= '0;
            tx_cnt <= '0;
            rx_rp  <= '0;
            rx_wp  <= '0;
            rx_cnt <= '0;
            err    <= '0;
        end else begin
            if (tx_pop_ok) tx_rp <= tx_rp + AW'(1);
            if (tx_wr_ok)  tx_wp <= tx_wp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_wr_ok) - CW'(tx_pop_ok);

            if (rx_rd_ok) rx_rp <= rx_rp + AW'(1);
            if (rx_wr_ok) rx_wp <= rx_wp + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_wr_ok) - CW'(rx_rd_ok);

            err <= err | {rx_ovf, pop_empty, tx_ovf};
        end
    end

`ifdef ENDPOINT_ID_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misroute_cnt <= '0;
        end else if (misroute && (misroute_cnt != 8'hFF)) begin
            misroute_cnt <= misroute_cnt + 8'd1;
        end
    end
`endif

endmodule
